// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: shared SAP-1.5 architecture types, control word layout and opcode map.
package arch_defs_pkg;
    localparam int OPCODE_WIDTH = 4;
    localparam int MAX_STEPS    = 8;
    localparam int STEP_WIDTH   = $clog2(MAX_STEPS);
    localparam int CW_WIDTH     = 20;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [STEP_WIDTH-1:0]   step_t;
    typedef logic [CW_WIDTH-1:0]     cw_vec_t;

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_FETCH_0 = 3'd1,
        S_FETCH_1 = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } fsm_state_t;

    typedef struct packed {
        logic halt;
        logic last_step;
        logic check_zero;
        logic check_carry;
        logic load_pc;
        logic pc_enable;
        logic oe_pc;
        logic load_mar;
        logic oe_ram;
        logic ram_we;
        logic load_ir;
        logic oe_ir;
        logic load_a;
        logic oe_a;
        logic load_b;
        logic oe_b;
        logic oe_alu;
        logic alu_sub;
        logic load_out;
        logic load_flags;
    } control_word_t;

    typedef struct packed {
        opcode_t opcode;
        step_t   step;
    } uaddr_t;

    // Single-bit masks in the same bit order as control_word_t.
    localparam cw_vec_t M_HALT        = cw_vec_t'(1) << 19;
    localparam cw_vec_t M_LAST        = cw_vec_t'(1) << 18;
    localparam cw_vec_t M_CHECK_ZERO  = cw_vec_t'(1) << 17;
    localparam cw_vec_t M_CHECK_CARRY = cw_vec_t'(1) << 16;
    localparam cw_vec_t M_LOAD_PC     = cw_vec_t'(1) << 15;
    localparam cw_vec_t M_PC_ENABLE   = cw_vec_t'(1) << 14;
    localparam cw_vec_t M_OE_PC       = cw_vec_t'(1) << 13;
    localparam cw_vec_t M_LOAD_MAR    = cw_vec_t'(1) << 12;
    localparam cw_vec_t M_OE_RAM      = cw_vec_t'(1) << 11;
    localparam cw_vec_t M_RAM_WE      = cw_vec_t'(1) << 10;
    localparam cw_vec_t M_LOAD_IR     = cw_vec_t'(1) << 9;
    localparam cw_vec_t M_OE_IR       = cw_vec_t'(1) << 8;
    localparam cw_vec_t M_LOAD_A      = cw_vec_t'(1) << 7;
    localparam cw_vec_t M_OE_A        = cw_vec_t'(1) << 6;
    localparam cw_vec_t M_LOAD_B      = cw_vec_t'(1) << 5;
    localparam cw_vec_t M_OE_B        = cw_vec_t'(1) << 4;
    localparam cw_vec_t M_OE_ALU      = cw_vec_t'(1) << 3;
    localparam cw_vec_t M_ALU_SUB     = cw_vec_t'(1) << 2;
    localparam cw_vec_t M_LOAD_OUT    = cw_vec_t'(1) << 1;
    localparam cw_vec_t M_LOAD_FLAGS  = cw_vec_t'(1) << 0;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_LDA  = 4'h1;
    localparam opcode_t OP_ADD  = 4'h2;
    localparam opcode_t OP_SUB  = 4'h3;
    localparam opcode_t OP_STA  = 4'h4;
    localparam opcode_t OP_LDI  = 4'h5;
    localparam opcode_t OP_JMP  = 4'h6;
    localparam opcode_t OP_JC   = 4'h7;
    localparam opcode_t OP_JZC  = 4'hA;
    localparam opcode_t OP_JZ   = 4'hB;
    localparam opcode_t OP_WALK = 4'hD;
    localparam opcode_t OP_OUT  = 4'hE;
    localparam opcode_t OP_HLT  = 4'hF;
endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: combinational {opcode, step} -> control word lookup holding every opcode table.
module microcode_rom
    import arch_defs_pkg::*;
(
    input  uaddr_t        addr,
    output control_word_t word
);
    localparam step_t S2 = step_t'(2);
    localparam step_t S3 = step_t'(3);
    localparam step_t S4 = step_t'(4);
    step_t s;
    assign s = addr.step;
    // WALK never sets last_step and relies on the sequencer's runaway return.
    always_comb begin
        word = '0;
        case (addr.opcode)
            OP_LDA:  word = (s == S2) ? (M_OE_IR | M_LOAD_MAR)
                          : (s == S3) ? (M_OE_RAM | M_LOAD_A | M_LAST) : '0;
            OP_ADD:  word = (s == S2) ? (M_OE_IR | M_LOAD_MAR)
                          : (s == S3) ? (M_OE_RAM | M_LOAD_B)
                          : (s == S4) ? (M_OE_ALU | M_LOAD_A | M_LOAD_FLAGS | M_LAST) : '0;
            OP_SUB:  word = (s == S2) ? (M_OE_IR | M_LOAD_MAR)
                          : (s == S3) ? (M_OE_RAM | M_LOAD_B)
                          : (s == S4) ? (M_OE_ALU | M_ALU_SUB | M_LOAD_A | M_LOAD_FLAGS | M_LAST) : '0;
            OP_STA:  word = (s == S2) ? (M_OE_IR | M_LOAD_MAR)
                          : (s == S3) ? (M_OE_A | M_RAM_WE | M_LAST) : '0;
            OP_LDI:  word = (s == S2) ? (M_OE_IR | M_LOAD_A | M_LAST) : '0;
            OP_JMP:  word = (s == S2) ? (M_OE_IR | M_LOAD_PC | M_LAST) : '0;
            OP_JC:   word = (s == S2) ? (M_OE_IR | M_LOAD_PC | M_CHECK_CARRY | M_LAST) : '0;
            OP_JZC:  word = (s == S2) ? (M_OE_IR | M_LOAD_PC | M_CHECK_ZERO | M_CHECK_CARRY | M_LAST) : '0;
            OP_JZ:   word = (s == S2) ? (M_OE_IR | M_LOAD_PC | M_CHECK_ZERO | M_LAST) : '0;
            OP_WALK: word = (s >= S2) ? (M_OE_A | M_LOAD_B) : '0;
            OP_OUT:  word = (s == S2) ? (M_OE_A | M_LOAD_OUT | M_LAST) : '0;
            OP_HLT:  word = (s == S2) ? (M_HALT | M_LAST) : '0;
            default: word = (s == S2) ? M_LAST : '0;
        endcase
    end
endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: fetch/execute FSM driving the SAP-1.5 control word from microcode_rom.
// Optional SEQ_SINGLE_STEP_EN adds step_req; the sequencer then advances only on requested cycles.
module microcode_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int MAX_STEPS    = 8,
    parameter int CW_WIDTH     = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [OPCODE_WIDTH-1:0]      opcode,
    input  logic                         flag_zero,
    input  logic                         flag_carry,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                         step_req,
`endif
    output logic [CW_WIDTH-1:0]          control_word,
    output logic [$clog2(MAX_STEPS)-1:0] microstep,
    output logic [2:0]                   state,
    output logic                         halted
);
    import arch_defs_pkg::*;
    localparam int SW = $clog2(MAX_STEPS);

    fsm_state_t    state_d, state_q;
    logic [SW-1:0] step_d, step_q;
    logic          halted_d, halted_q;
    control_word_t rom_word, exec_word;
    cw_vec_t       cw;
    logic          advance, jump_ok, runaway;

    microcode_rom u_rom (
        .addr ({opcode, step_q}),
        .word (rom_word)
    );

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = step_req;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        jump_ok = (!rom_word.check_zero || flag_zero) && (!rom_word.check_carry || flag_carry);
        runaway = step_q == SW'(MAX_STEPS - 1);
        exec_word = rom_word;
        exec_word.load_pc = rom_word.load_pc && jump_ok;
        exec_word.last_step = rom_word.last_step || runaway;
        cw = (state_q == S_FETCH_0) ? (M_OE_PC | M_LOAD_MAR)
           : (state_q == S_FETCH_1) ? (M_OE_RAM | M_LOAD_IR | M_PC_ENABLE)
           : (state_q == S_EXECUTE) ? exec_word
           : (state_q == S_HALT)    ? M_HALT : '0;
        state_d = state_q;
        step_d = step_q;
        if (advance) begin
            case (state_q)
                S_RESET:   begin state_d = S_FETCH_0; step_d = '0; end
                S_FETCH_0: begin state_d = S_FETCH_1; step_d = SW'(1); end
                S_FETCH_1: begin state_d = S_EXECUTE; step_d = SW'(2); end
                S_EXECUTE: begin
                    state_d = exec_word.halt ? S_HALT : exec_word.last_step ? S_FETCH_0 : S_EXECUTE;
                    step_d = exec_word.halt ? step_q : exec_word.last_step ? '0 : step_q + 1'b1;
                end
                default:   state_d = state_q;
            endcase
        end
        halted_d = state_d == S_HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RESET;
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Holding cycles and reset cycles emit nothing so datapath side effects never repeat.
    assign control_word = (reset || !advance) ? '0 : cw;
    assign microstep    = step_q;
    assign state        = state_q;
    assign halted       = halted_q;
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: directed instruction stream checked cycle by cycle against a microprogram model.
module tb_microcode_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fz = 1'b0;
    logic        fc = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [19:0] control_word;
    logic [2:0]  microstep;
    logic [2:0]  state;
    logic        halted;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step_req = 1'b1;
`endif

    always #5 clk = ~clk;

    microcode_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .flag_zero    (fz),
        .flag_carry   (fc),
`ifdef SEQ_SINGLE_STEP_EN
        .step_req     (step_req),
`endif
        .control_word (control_word),
        .microstep    (microstep),
        .state        (state),
        .halted       (halted)
    );

    localparam logic [2:0]  ST_RST = 3'd0, ST_F0 = 3'd1, ST_F1 = 3'd2, ST_EX = 3'd3, ST_HLT = 3'd4;
    localparam logic [19:0] B_HALT = 20'h80000, B_LAST = 20'h40000, B_CZ = 20'h20000;
    localparam logic [19:0] B_CC = 20'h10000, B_LDPC = 20'h08000;
    localparam logic [19:0] W_F0 = 20'h03000, W_F1 = 20'h04A00;

    typedef struct {
        logic [2:0]  st;
        int          stp;
        logic [19:0] w;
    } item_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_on = 1'b0;
    logic [2:0]  exp_st;
    int          exp_stp;
    logic [19:0] exp_cw;
    logic        exp_hl;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            check("control_word", 32'(control_word), 32'(exp_cw));
            check("state", 32'(state), 32'(exp_st));
            check("halted", 32'(halted), 32'(exp_hl));
            if (exp_stp >= 0) check("microstep", 32'(microstep), 32'(exp_stp));
        end
    end

    // Execute-phase words per opcode, before flag gating and runaway forcing.
    function automatic logic [19:0] prog(input logic [3:0] op, input int i);
        case (op)
            4'h1: return i == 0 ? 20'h01100 : i == 1 ? 20'h40880 : 20'h0;
            4'h2: return i == 0 ? 20'h01100 : i == 1 ? 20'h00820 : i == 2 ? 20'h40089 : 20'h0;
            4'h3: return i == 0 ? 20'h01100 : i == 1 ? 20'h00820 : i == 2 ? 20'h4008D : 20'h0;
            4'h4: return i == 0 ? 20'h01100 : i == 1 ? 20'h40440 : 20'h0;
            4'h5: return i == 0 ? 20'h40180 : 20'h0;
            4'h6: return i == 0 ? 20'h48100 : 20'h0;
            4'h7: return i == 0 ? 20'h58100 : 20'h0;
            4'hA: return i == 0 ? 20'h78100 : 20'h0;
            4'hB: return i == 0 ? 20'h68100 : 20'h0;
            4'hD: return 20'h00060;
            4'hE: return i == 0 ? 20'h40042 : 20'h0;
            4'hF: return i == 0 ? 20'hC0000 : 20'h0;
            default: return i == 0 ? 20'h40000 : 20'h0;
        endcase
    endfunction

    task automatic cyc(input logic [2:0] st, input int stp, input logic [19:0] w, input logic hl,
                       input logic [3:0] op, input logic rs, input logic sr);
        reset = rs;
        opcode = op;
`ifdef SEQ_SINGLE_STEP_EN
        step_req = sr;
`else
        if (!sr) $display("note: step_req ignored without single-step build");
`endif
        exp_st = st;
        exp_stp = stp;
        exp_cw = w;
        exp_hl = hl;
        exp_on = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One whole instruction; per>1 inserts per-1 holding cycles before each advance,
    // stop_at>=2 asserts reset on that execute step instead of finishing.
    task automatic run_instr(input logic [3:0] op, input logic z, input logic c, input int per, input int stop_at);
        item_t q[$];
        logic [19:0] w;
        fz = z;
        fc = c;
        q.push_back('{ST_F0, 0, W_F0});
        q.push_back('{ST_F1, 1, W_F1});
        for (int i = 0; i < 6; i++) begin
            w = prog(op, i);
            if (((w & B_CZ) != 0 && !z) || ((w & B_CC) != 0 && !c)) w = w & ~B_LDPC;
            if (i == 5 && (w & B_HALT) == 0) w = w | B_LAST;
            q.push_back('{ST_EX, i + 2, w});
            if ((w & (B_LAST | B_HALT)) != 0) break;
        end
        foreach (q[k]) begin
            for (int h = 0; h < per; h++) begin
                if (q[k].stp == stop_at) begin
                    cyc(q[k].st, q[k].stp, 20'h0, 1'b0, op, 1'b1, 1'b0);
                    cyc(ST_RST, 0, 20'h0, 1'b0, op, 1'b0, 1'b1);
                    return;
                end
                cyc(q[k].st, q[k].stp, (h == per - 1) ? q[k].w : 20'h0, 1'b0,
                    (q[k].st == ST_EX) ? op : ~op, 1'b0, h == per - 1);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(ST_RST, 0, 20'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        cyc(ST_RST, 0, 20'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("pin_fetch0_cw", 32'(control_word), 32'h03000);
        check("pin_fetch0_state", 32'(state), 32'd1);
        run_instr(4'h1, 1'b0, 1'b0, 1, -1);
        check("pin_after_lda_state", 32'(state), 32'd1);
        run_instr(4'hB, 1'b1, 1'b0, 1, -1);
        run_instr(4'hB, 1'b0, 1'b1, 1, -1);
        run_instr(4'h7, 1'b0, 1'b1, 1, -1);
        run_instr(4'h7, 1'b1, 1'b0, 1, -1);
        run_instr(4'hA, 1'b1, 1'b1, 1, -1);
        run_instr(4'hA, 1'b1, 1'b0, 1, -1);
        run_instr(4'hA, 1'b0, 1'b1, 1, -1);
        run_instr(4'h2, 1'b0, 1'b0, 1, -1);
        run_instr(4'h3, 1'b1, 1'b1, 1, -1);
        run_instr(4'h0, 1'b0, 1'b0, 1, -1);
        run_instr(4'hC, 1'b0, 1'b0, 1, -1);
        run_instr(4'hD, 1'b0, 1'b0, 1, -1);
        run_instr(4'h4, 1'b0, 1'b0, 1, -1);
        run_instr(4'h5, 1'b0, 1'b0, 1, -1);
        run_instr(4'h6, 1'b0, 1'b0, 1, -1);
        run_instr(4'hE, 1'b0, 1'b0, 1, -1);
        run_instr(4'h2, 1'b0, 1'b0, 1, 3);
        run_instr(4'h1, 1'b0, 1'b0, 1, -1);
        run_instr(4'hF, 1'b0, 1'b0, 1, -1);
        check("pin_halted", 32'(halted), 32'd1);
        check("pin_halt_cw", 32'(control_word), 32'h80000);
        for (int i = 0; i < 20; i++) cyc(ST_HLT, -1, B_HALT, 1'b1, 4'(i), 1'b0, 1'b1);
        cyc(ST_HLT, -1, 20'h0, 1'b1, 4'h0, 1'b1, 1'b1);
        cyc(ST_RST, 0, 20'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        run_instr(4'h0, 1'b0, 1'b0, 1, -1);
`ifdef SEQ_SINGLE_STEP_EN
        run_instr(4'h1, 1'b0, 1'b0, 4, -1);
        run_instr(4'hB, 1'b1, 1'b0, 4, -1);
        run_instr(4'h2, 1'b0, 1'b0, 4, 3);
        run_instr(4'h5, 1'b0, 1'b0, 1, -1);
`endif
        exp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
